// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: bundles the fetch unit's three handshakes.
//   redirect_*            : next-PC mux -> fetch unit (new target this cycle)
//   imem_req/addr/gnt     : request channel to instruction memory
//   imem_rvalid/rdata     : response channel from instruction memory
//   instr_valid/ready/out/pc : one-entry output buffer towards decode
// Modport master is the fetch unit side, slave is the surrounding environment.
interface fetch_pc_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_out;
    logic [DATA_WIDTH-1:0] instr_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr_out, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr_out, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and instruction-fetch stage.
// Keeps the PC, issues one word fetch at a time over req/gnt/rvalid and
// parks each returned instruction in a one-entry valid/ready buffer.
// A redirect reloads the PC, empties the buffer and drops any response
// that is still in flight.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_pc_unit_if.master (redirect, imem request/response, decode buffer)
module fetch_pc_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_unit_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  kill_q, kill_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] instr_out_q, instr_out_d;
    logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;

    logic                  consume;
    logic                  buf_free;
    logic                  fire;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_aligned;
    logic                  unused_redirect_lsbs;

    assign consume  = instr_valid_q & bus.instr_ready;
    // Only request when the returned word is guaranteed a slot in the buffer.
    assign buf_free = ~instr_valid_q | bus.instr_ready;
    assign fire     = (state_q == REQ) & buf_free & bus.imem_gnt;
    // Redirects are not accepted in the single post-reset IDLE cycle.
    assign redirect = bus.redirect_valid & (state_q != IDLE);
    assign redirect_aligned = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
    // Target low bits are discarded; fetches are always word aligned.
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q & ~consume;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (fire) begin
                    state_d = WAIT;
                    // Memory has taken the old address; its reply must be dropped.
                    if (redirect) kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    // The response closes the outstanding fetch whether or
                    // not it is kept, so kill never outlives it.
                    state_d = REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect) begin
                        instr_valid_d = 1'b1;
                        instr_out_d   = bus.imem_rdata;
                        instr_pc_d    = pc_q;
                        pc_d          = pc_q + DATA_WIDTH'(4);
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Redirect wins over any reload or increment in the same cycle.
        if (redirect) begin
            pc_d          = redirect_aligned;
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign bus.imem_req    = (state_q == REQ) & buf_free;
    assign bus.imem_addr   = {pc_q[DATA_WIDTH-1:2], 2'b00};
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
`timescale 1ns/1ps
module tb_fetch_pc_unit;
    localparam int          DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_unit_if #(.DATA_WIDTH(DW)) bus();
    fetch_pc_unit #(.DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel_cyc = 0;

    // Scoreboard: PCs decode must see next, in order.
    logic [31:0] exp_q[$];
    logic [31:0] gnt_log[$];
    int          hs_cyc[$];

    // Stimulus knobs.
    bit mem_en     = 1'b0;
    int gnt_pct    = 100;
    int lat_min    = 1;
    int lat_max    = 1;
    int rdy_pct    = 100;
    bit rdy_manual = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents; word 0 holds 32'h13 (nop).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected stream restarts at pc and then runs sequentially (mod 2^32).
    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    // ---------------- decode-side monitor ----------------
    initial begin : monitor
        logic [31:0] p_out, p_pc, e;
        bit stall, p_redir;
        stall = 1'b0; p_redir = 1'b0; p_out = '0; p_pc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                continue;
            end
            if (stall && !p_redir) begin
                chk("hold_valid", 32'(bus.instr_valid), 32'd1);
                chk("hold_out", bus.instr_out, p_out);
                chk("hold_pc", bus.instr_pc, p_pc);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                hs_cyc.push_back(cyc);
                e = exp_q.pop_front();
                exp_q.push_back(exp_q[$] + 32'd4);
                chk("instr_pc", bus.instr_pc, e);
                chk("instr_out", bus.instr_out, mem_word(e));
            end
            stall   = bus.instr_valid && !bus.instr_ready;
            p_out   = bus.instr_out;
            p_pc    = bus.instr_pc;
            p_redir = bus.redirect_valid;
        end
    end

    // ---------------- instruction memory model ----------------
    initial begin : mem_model
        bit pend;
        int cnt;
        logic [31:0] a;
        pend = 1'b0; cnt = 0; a = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en && !rst) begin
                if (bus.imem_rvalid) pend = 1'b0;
                if (bus.imem_req && bus.imem_gnt) begin
                    chk("one_outstanding", 32'(pend), 32'd0);
                    chk("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
                    gnt_log.push_back(bus.imem_addr);
                    pend = 1'b1;
                    a    = bus.imem_addr;
                    cnt  = lat_min - 1 + int'($urandom_range(0, lat_max - lat_min));
                end
            end
            @(posedge clk);
            #1;
            if (mem_en) begin
                if (rst) pend = 1'b0;
                bus.imem_rvalid = 1'b0;
                if (pend) begin
                    if (cnt == 0) begin
                        bus.imem_rvalid = 1'b1;
                        bus.imem_rdata  = mem_word(a);
                    end else begin
                        cnt--;
                    end
                end
                bus.imem_gnt = ($urandom_range(0, 99) < gnt_pct);
            end else begin
                pend = 1'b0;
            end
        end
    end

    // ---------------- decode ready driver ----------------
    initial begin : dec_model
        bus.instr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rdy_manual) bus.instr_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Called at posedge+1; the redirect takes effect at the next edge.
    task automatic redirect(input logic [31:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = t;
        @(posedge clk);
        start_stream({t[31:2], 2'b00});
        #1 bus.redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        mem_en = 1'b0;
        rst    = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        start_stream(RST_PC);
        gnt_log.delete();
        hs_cyc.delete();
        rst     = 1'b0;
        rel_cyc = cyc;
        mem_en  = 1'b1;
    endtask

    // Returns at posedge+1 of the edge that logged grant number n.
    task automatic wait_grant(input int n, input string name);
        int t = 0;
        while (gnt_log.size() < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (gnt_log.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no grant %0d within 200 cycles", name, n);
        end
    endtask

    function automatic logic [31:0] glog(input int i);
        return (gnt_log.size() > i) ? gnt_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int t, idx;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset values.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_out", bus.instr_out, 32'd0);
        chk("rst_pc", bus.instr_pc, 32'd0);

        // 1: full-rate sequential fetch.
        gnt_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 100; rdy_manual = 1'b0;
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        chk("t1_gnt0", glog(0), 32'h0);
        chk("t1_gnt1", glog(1), 32'h4);
        chk("t1_gnt2", glog(2), 32'h8);
        chk("t1_first_hs", 32'(hs_cyc.size() > 0 ? hs_cyc[0] : -1), 32'(rel_cyc + 3));
        for (int i = 1; i < 4; i++)
            chk("t1_rate", 32'(hs_cyc.size() > i ? hs_cyc[i] - hs_cyc[i-1] : -1), 32'd2);

        // 2: decode backpressure after the first instruction.
        rdy_manual = 1'b1; bus.instr_ready = 1'b0;
        do_reset();
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.instr_valid && t < 50);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t2_valid", 32'(bus.instr_valid), 32'd1);
            chk("t2_pc", bus.instr_pc, 32'h0);
            chk("t2_out", bus.instr_out, mem_word(32'h0));
            chk("t2_req_low", 32'(bus.imem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1; rdy_manual = 1'b0;
        wait_grant(2, "t2_grant");
        chk("t2_gnt1", glog(1), 32'h4);
        repeat (10) @(posedge clk);
        #1;

        // 3: redirect while a fetch is outstanding.
        lat_min = 4; lat_max = 4;
        do_reset();
        wait_grant(1, "t3_grant");
        redirect(32'h0000_0102);
        wait_grant(2, "t3_grant2");
        chk("t3_gnt_redir", glog(1), 32'h0000_0100);
        repeat (15) @(posedge clk);
        #1;

        // 4: redirect in the same cycle as the rvalid for addr 8.
        lat_min = 1; lat_max = 1;
        do_reset();
        wait_grant(3, "t4_grant");
        chk("t4_gnt8", glog(2), 32'h8);
        redirect(32'h0000_0040);
        wait_grant(4, "t4_grant2");
        chk("t4_gnt_redir", glog(3), 32'h0000_0040);
        repeat (10) @(posedge clk);
        #1;

        // 5: PC wrap.
        redirect(32'hFFFF_FFFC);
        repeat (12) @(posedge clk);
        #1;
        idx = -1;
        for (int i = 0; i < gnt_log.size(); i++)
            if (gnt_log[i] == 32'hFFFF_FFFC && idx < 0) idx = i;
        chk("t5_found", 32'(idx >= 0), 32'd1);
        chk("t5_wrap", glog(idx + 1), 32'h0);

        // 6: reset while WAIT, stale rvalid in IDLE and REQ.
        lat_min = 8; lat_max = 8;
        do_reset();
        wait_grant(1, "t6_grant");
        mem_en = 1'b0;
        bus.imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_req", 32'(bus.imem_req), 32'd0);
        chk("t6_addr", bus.imem_addr, RST_PC);
        chk("t6_valid", 32'(bus.instr_valid), 32'd0);
        chk("t6_out", bus.instr_out, 32'd0);
        chk("t6_pc", bus.instr_pc, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_0BAD;
        @(negedge clk);
        start_stream(RST_PC);
        gnt_log.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_req_after", 32'(bus.imem_req), 32'd1);
        chk("t6_addr_after", bus.imem_addr, RST_PC);
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        lat_min = 1; lat_max = 2;
        mem_en = 1'b1;
        @(negedge clk);
        chk("t6_stale_ignored", 32'(bus.instr_valid), 32'd0);
        wait_grant(1, "t6_grant2");
        chk("t6_first_addr", glog(0), RST_PC);
        repeat (10) @(posedge clk);
        #1;

        // Random traffic with random redirects.
        gnt_pct = 60; lat_min = 1; lat_max = 3; rdy_pct = 70;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 4) redirect(pick_target());
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("rand_progress", 32'(hs_cyc.size() >= 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
